// File: rtl/opcol_exec_skid_stage.sv
// Operand-collector to execute pipeline stage.
// Two-entry skid buffer: "main" drives the execute lanes, "skid" catches the
// one extra packet that can arrive after execute deasserts ready. in_ready_o
// comes straight from registered state, so execute backpressure never reaches
// the collector in the same cycle. Supports warp-selective or global flush
// with a saturating drop counter, and optional zeroing of inactive lanes.
module opcol_exec_skid_stage #(
    parameter int NUM_LANES     = 32,
    parameter int LANE_W        = 96,
    parameter int PKT_W         = 160,
    parameter int SM_W          = 4,
    parameter int WARP_W        = 5,
    parameter bit GATE_INACTIVE = 1'b1,
    parameter int DROP_W        = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [SM_W-1:0]               in_sm_i,
    input  logic [WARP_W-1:0]             in_warp_i,
    input  logic [PKT_W-1:0]              in_packet_i,
    input  logic [NUM_LANES-1:0]          in_mask_i,
    input  logic [NUM_LANES*LANE_W-1:0]   in_lanes_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [SM_W-1:0]               out_sm_o,
    output logic [WARP_W-1:0]             out_warp_o,
    output logic [PKT_W-1:0]              out_packet_o,
    output logic [NUM_LANES-1:0]          out_mask_o,
    output logic [NUM_LANES*LANE_W-1:0]   out_lanes_o,
    input  logic                          flush_i,
    input  logic                          flush_all_i,
    input  logic [WARP_W-1:0]             flush_warp_i,
    output logic [1:0]                    count_o,
    output logic [DROP_W-1:0]             drop_cnt_o
);

    localparam int CNT_W = DROP_W + 1;

    typedef struct packed {
        logic [SM_W-1:0]             sm;
        logic [WARP_W-1:0]           warp;
        logic [PKT_W-1:0]            packet;
        logic [NUM_LANES-1:0]        mask;
        logic [NUM_LANES*LANE_W-1:0] lanes;
    } entry_t;

    // Occupancy doubles as the state: main is valid in ONE/FULL, skid only in FULL.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    entry_t            main_q;
    entry_t            skid_q;
    entry_t            main_next;
    entry_t            skid_next;
    entry_t            in_entry;
    entry_t            pre_main;
    entry_t            pre_skid;
    logic              pre_main_v;
    logic              pre_skid_v;
    logic              main_hit;
    logic              skid_hit;
    logic              keep_main;
    logic              keep_skid;
    logic              main_valid;
    logic              skid_valid;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  drop_sum;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_next;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign push       = in_valid_i & ~skid_valid;
    assign pop        = main_valid & out_ready_i;

    // Build the incoming entry, zeroing inactive lanes when gating is enabled; the mask itself is kept as-is.
    always_comb begin
        in_entry.sm     = in_sm_i;
        in_entry.warp   = in_warp_i;
        in_entry.packet = in_packet_i;
        in_entry.mask   = in_mask_i;
        in_entry.lanes  = in_lanes_i;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (GATE_INACTIVE && !in_mask_i[k]) begin
                in_entry.lanes[k*LANE_W +: LANE_W] = '0;
            end
        end
    end

    // Apply pop then push to get the nominal next contents, then let flush invalidate matches and compact skid into main.
    always_comb begin
        pre_main   = main_q;
        pre_skid   = skid_q;
        pre_main_v = main_valid;
        pre_skid_v = skid_valid;
        if (pop) begin
            pre_main   = skid_q;
            pre_main_v = skid_valid;
            pre_skid_v = 1'b0;
        end
        if (push) begin
            if (pre_main_v) begin
                pre_skid   = in_entry;
                pre_skid_v = 1'b1;
            end else begin
                pre_main   = in_entry;
                pre_main_v = 1'b1;
            end
        end

        main_hit  = flush_i & pre_main_v & (flush_all_i | (pre_main.warp == flush_warp_i));
        skid_hit  = flush_i & pre_skid_v & (flush_all_i | (pre_skid.warp == flush_warp_i));
        keep_main = pre_main_v & ~main_hit;
        keep_skid = pre_skid_v & ~skid_hit;

        main_next = pre_main;
        skid_next = pre_skid;
        if (!keep_main && keep_skid) begin
            main_next = pre_skid;
            keep_main = 1'b1;
            keep_skid = 1'b0;
        end

        if (keep_skid) begin
            state_next = FULL;
        end else if (keep_main) begin
            state_next = ONE;
        end else begin
            state_next = EMPTY;
        end

        drop_sum  = {1'b0, drop_cnt} + CNT_W'(main_hit) + CNT_W'(skid_hit);
        drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end

    // Register occupancy, both payload slots and the drop counter; reset wipes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            main_q   <= main_next;
            skid_q   <= skid_next;
            drop_cnt <= drop_next;
        end
    end

    assign in_ready_o   = ~skid_valid;
    assign out_valid_o  = main_valid;
    assign count_o      = state;
    assign drop_cnt_o   = drop_cnt;
    assign out_sm_o     = main_q.sm;
    assign out_warp_o   = main_q.warp;
    assign out_packet_o = main_q.packet;
    assign out_mask_o   = main_q.mask;
    assign out_lanes_o  = main_q.lanes;

endmodule

// File: tb/tb_opcol_exec_skid_stage.sv
// Directed bench for opcol_exec_skid_stage. A queue model (at most two
// packets, FIFO order, flush removes matching packets) predicts the outputs
// every cycle; literal expectations pin key scenarios independently.
module tb_opcol_exec_skid_stage;

    localparam int NUM_LANES = 32;
    localparam int LANE_W    = 96;
    localparam int PKT_W     = 160;
    localparam int SM_W      = 4;
    localparam int WARP_W    = 5;
    localparam int DROP_W    = 8;
    localparam int LW        = NUM_LANES * LANE_W;
    localparam int DROP_MAX  = 255;

    typedef struct packed {
        logic [SM_W-1:0]      sm;
        logic [WARP_W-1:0]    warp;
        logic [PKT_W-1:0]     packet;
        logic [NUM_LANES-1:0] mask;
        logic [LW-1:0]        lanes;
    } ent_t;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [SM_W-1:0]      in_sm;
    logic [WARP_W-1:0]    in_warp;
    logic [PKT_W-1:0]     in_packet;
    logic [NUM_LANES-1:0] in_mask;
    logic [LW-1:0]        in_lanes;
    logic                 out_valid;
    logic                 out_ready;
    logic [SM_W-1:0]      out_sm;
    logic [WARP_W-1:0]    out_warp;
    logic [PKT_W-1:0]     out_packet;
    logic [NUM_LANES-1:0] out_mask;
    logic [LW-1:0]        out_lanes;
    logic                 flush;
    logic                 flush_all;
    logic [WARP_W-1:0]    flush_warp;
    logic [1:0]           count;
    logic [DROP_W-1:0]    drop_cnt;

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    int   m_drop   = 0;

    opcol_exec_skid_stage #(
        .NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .PKT_W(PKT_W), .SM_W(SM_W),
        .WARP_W(WARP_W), .GATE_INACTIVE(1'b1), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_sm_i(in_sm), .in_warp_i(in_warp), .in_packet_i(in_packet),
        .in_mask_i(in_mask), .in_lanes_i(in_lanes),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sm_o(out_sm), .out_warp_o(out_warp), .out_packet_o(out_packet),
        .out_mask_o(out_mask), .out_lanes_o(out_lanes),
        .flush_i(flush), .flush_all_i(flush_all), .flush_warp_i(flush_warp),
        .count_o(count), .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] makeLanes(logic [31:0] tag, bit vary);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            l[k*LANE_W +: LANE_W] = {tag, tag, tag} ^ (vary ? LANE_W'(k) : '0);
        end
        return l;
    endfunction

    task automatic checkOutput(string name, logic [PKT_W-1:0] actual, logic [PKT_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkLanes(string name, logic [LW-1:0] actual, logic [LW-1:0] expected);
        int bad;
        bad = -1;
        checks++;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (actual[k*LANE_W +: LANE_W] !== expected[k*LANE_W +: LANE_W]) bad = k;
        end
        if (bad >= 0) begin
            failures++;
            $display("[TB] FAIL %s lane%0d actual=%h expected=%h at %0t", name, bad,
                     actual[bad*LANE_W +: LANE_W], expected[bad*LANE_W +: LANE_W], $time);
        end
    endtask

    // Model: pop the oldest if execute takes it, append the gated input if there was room, then remove flushed packets.
    function automatic void modelStep();
        ent_t e;
        bit   do_push;
        bit   do_pop;
        int   dropped;
        do_push = in_valid && (q.size() < 2);
        do_pop  = (q.size() > 0) && out_ready;
        e.sm     = in_sm;
        e.warp   = in_warp;
        e.packet = in_packet;
        e.mask   = in_mask;
        e.lanes  = in_lanes;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!in_mask[k]) e.lanes[k*LANE_W +: LANE_W] = '0;
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        if (flush) begin
            dropped = 0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (flush_all || q[i].warp == flush_warp) begin
                    q.delete(i);
                    dropped++;
                end
            end
            m_drop = (m_drop + dropped > DROP_MAX) ? DROP_MAX : m_drop + dropped;
        end
    endfunction

    function automatic void modelReset();
        q.delete();
        m_drop = 0;
    endfunction

    // Advance the model on every clock edge, or clear it on reset.
    always @(posedge clk or posedge reset) begin
        if (reset) modelReset();
        else modelStep();
    end

    task automatic compareModel();
        checkOutput("out_valid", 160'(out_valid), 160'(q.size() > 0));
        checkOutput("in_ready", 160'(in_ready), 160'(q.size() < 2));
        checkOutput("count", 160'(count), 160'(q.size()));
        checkOutput("drop_cnt", 160'(drop_cnt), 160'(m_drop));
        if (q.size() > 0) begin
            checkOutput("out_sm", 160'(out_sm), 160'(q[0].sm));
            checkOutput("out_warp", 160'(out_warp), 160'(q[0].warp));
            checkOutput("out_packet", out_packet, q[0].packet);
            checkOutput("out_mask", 160'(out_mask), 160'(q[0].mask));
            checkLanes("out_lanes", out_lanes, q[0].lanes);
        end
    endtask

    // Compare against the model in the middle of every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) compareModel();
    end

    task automatic applyStimulus(bit valid, logic [SM_W-1:0] sm, logic [WARP_W-1:0] warp,
                                 logic [31:0] tag, logic [NUM_LANES-1:0] mask, bit vary,
                                 bit ready, bit fl, bit fl_all, logic [WARP_W-1:0] fl_warp);
        in_valid   = valid;
        in_sm      = sm;
        in_warp    = warp;
        in_packet  = {tag, tag, tag, tag, tag};
        in_mask    = mask;
        in_lanes   = makeLanes(tag, vary);
        out_ready  = ready;
        flush      = fl;
        flush_all  = fl_all;
        flush_warp = fl_warp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(bit ready, int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 32'h0, '0, 1'b0, ready, 1'b0, 1'b0, '0);
    endtask

    logic [LANE_W-1:0] aa_lane;

    initial begin
        aa_lane = {12{8'hAA}};
        reset = 1'b1;
        in_valid = 1'b0; in_sm = '0; in_warp = '0; in_packet = '0; in_mask = '0; in_lanes = '0;
        out_ready = 1'b0; flush = 1'b0; flush_all = 1'b0; flush_warp = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 160'(out_valid), 160'(0));
        checkOutput("rst_count", 160'(count), 160'(0));
        checkOutput("rst_in_ready", 160'(in_ready), 160'(1));
        checkOutput("rst_drop", 160'(drop_cnt), 160'(0));
        checkOutput("rst_packet", out_packet, 160'(0));
        reset = 1'b0;

        $display("[TB] single push");
        applyStimulus(1'b1, 4'd1, 5'd3, 32'h1000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("single_valid", 160'(out_valid), 160'(1));
        checkOutput("single_warp", 160'(out_warp), 160'(3));
        checkOutput("single_packet", out_packet, {5{32'h1000_0001}});
        idle(1'b1, 1);
        checkOutput("single_count_after", 160'(count), 160'(0));

        $display("[TB] stream of 8");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'(i), 5'(i + 8), 32'h2000_0000 + 32'(i), 32'hFFFF_FFFF, 1'b1,
                          1'b1, 1'b0, 1'b0, '0);
        end
        checkOutput("stream_last_warp", 160'(out_warp), 160'(15));
        idle(1'b1, 2);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 4'd2, 5'd10, 32'h3000_0010, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd2, 5'd11, 32'h3000_0011, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd2, 5'd12, 32'h3000_0012, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd2, 5'd13, 32'h3000_0013, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd2, 5'd13, 32'h3000_0013, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("bp_count", 160'(count), 160'(2));
        checkOutput("bp_in_ready", 160'(in_ready), 160'(0));
        checkOutput("bp_main_warp", 160'(out_warp), 160'(11));
        idle(1'b1, 1);
        checkOutput("bp_release_warp", 160'(out_warp), 160'(12));
        idle(1'b1, 2);

        $display("[TB] lane gating");
        applyStimulus(1'b1, 4'd3, 5'd1, 32'hAAAA_AAAA, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("gate_mask", 160'(out_mask), 160'(32'h0000_0005));
        checkOutput("gate_lane0", 160'(out_lanes[0*LANE_W +: LANE_W]), 160'(aa_lane));
        checkOutput("gate_lane1", 160'(out_lanes[1*LANE_W +: LANE_W]), 160'(0));
        checkOutput("gate_lane2", 160'(out_lanes[2*LANE_W +: LANE_W]), 160'(aa_lane));
        checkOutput("gate_lane31", 160'(out_lanes[31*LANE_W +: LANE_W]), 160'(0));
        idle(1'b1, 2);

        $display("[TB] selective flush");
        applyStimulus(1'b1, 4'd4, 5'd2, 32'h5000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd4, 5'd5, 32'h5000_0005, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
        checkOutput("sflush_warp", 160'(out_warp), 160'(5));
        checkOutput("sflush_count", 160'(count), 160'(1));
        checkOutput("sflush_drop", 160'(drop_cnt), 160'(1));
        idle(1'b1, 2);

        $display("[TB] flush all");
        applyStimulus(1'b1, 4'd6, 5'd1, 32'h6000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd6, 5'd4, 32'h6000_0004, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd6, 5'd7, 32'h6000_0007, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0);
        checkOutput("fall_pop_count", 160'(count), 160'(0));
        checkOutput("fall_pop_drop", 160'(drop_cnt), 160'(2));
        applyStimulus(1'b1, 4'd6, 5'd8, 32'h6000_0008, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd6, 5'd9, 32'h6000_0009, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd6, 5'd9, 32'h6000_0009, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        checkOutput("fall_full_count", 160'(count), 160'(0));
        checkOutput("fall_full_drop", 160'(drop_cnt), 160'(4));
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, 4'd7, 5'(i), 32'h7000_0000 + 32'(i), 32'hFFFF_FFFF, 1'b0,
                          1'b0, 1'b1, 1'b1, '0);
        end
        checkOutput("sat_drop", 160'(drop_cnt), 160'(255));
        checkOutput("sat_count", 160'(count), 160'(0));
        idle(1'b1, 1);

        $display("[TB] reset mid-transfer");
        applyStimulus(1'b1, 4'd8, 5'd3, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 4'd8, 5'd3, 32'h8000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 160'(out_valid), 160'(0));
        checkOutput("mid_rst_count", 160'(count), 160'(0));
        checkOutput("mid_rst_drop", 160'(drop_cnt), 160'(0));
        checkOutput("mid_rst_ready", 160'(in_ready), 160'(1));
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(1'b1, 4'd9, 5'd6, 32'h9000_0006, 32'h0F0F_0F0F, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("post_rst_warp", 160'(out_warp), 160'(6));
        idle(1'b1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opcol_exec_skid_stage.md
# opcol_exec_skid_stage

Parametrised operand-collector-to-execute pipeline stage with a 2-entry skid buffer, a valid/ready handshake in place of a global stall, warp-selective flush, and optional zeroing of inactive lanes. Sits between the operand collector's FU dispatch port and the execute-stage lane array. It cuts the combinational ready path so that the execute unit's backpressure never reaches the collector in the same cycle.

## Interface
- NUM_LANES, 32, SIMD lanes per packet
- LANE_W, 96, bits per lane (three 32-bit operands)
- PKT_W, 160, decoded instruction packet width
- SM_W, 4, SM id width
- WARP_W, 5, warp id width
- GATE_INACTIVE, 1, when 1 lanes with mask bit 0 are stored as all-zero
- DROP_W, 8, width of flush-drop counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid_i  in  1  upstream packet valid
- in_ready_o  out  1  stage can accept; equals ~skid_valid (registered, no combinational input path)
- in_sm_i  in  SM_W  SM id
- in_warp_i  in  WARP_W  warp id
- in_packet_i  in  PKT_W  instruction packet
- in_mask_i  in  NUM_LANES  active-lane mask
- in_lanes_i  in  NUM_LANES*LANE_W  lane operands; lane k at [k*LANE_W +: LANE_W]
- out_valid_o  out  1  main entry valid
- out_ready_i  in  1  execute accepts
- out_sm_o, out_warp_o, out_packet_o, out_mask_o, out_lanes_o  out  as inputs  main-entry payload
- flush_i  in  1  flush request
- flush_all_i  in  1  with flush_i: drop every warp; else only flush_warp_i
- flush_warp_i  in  WARP_W  warp to drop
- count_o  out  2  occupancy 0..2
- drop_cnt_o  out  DROP_W  saturating count of entries dropped by flush

## Operation
- Two entries: main (drives out_*) and skid. Order preserved: main is always older.
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- States by count_o: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push → input to main, ONE.
  - ONE: push & pop → input to main, ONE; push only → input to skid, FULL; pop only → EMPTY.
  - FULL: in_ready_o=0; pop → skid to main, ONE; else hold.
- Lane gating: if GATE_INACTIVE=1, lane k is written as 0 when in_mask_i[k]=0; the mask is stored unmodified. If GATE_INACTIVE=0, lanes pass unmodified.
- Flush (flush_i=1): an entry matches if flush_all_i=1 or its warp equals flush_warp_i.
  - Applied to the state after this cycle's push/pop. The pop handshake in the flush cycle completes and is not dropped.
  - A matching pushed input is dropped and counted. It is still handshaken, so upstream sees it accepted.
  - Matching entries are invalidated. A surviving skid entry moves to main, so count_o is recomputed.
  - drop_cnt_o increments by the number dropped (0..2) and saturates at 2^DROP_W-1.
- Invalid entries hold stale payload. Payload registers of invalid entries need not be cleared except on reset.

## Timing
- Reset (async) values: out_valid_o=0, all out_* payload=0, count_o=0, drop_cnt_o=0, skid_valid=0, hence in_ready_o=1. Inputs are ignored while reset is high.
- Latency: a push into EMPTY gives out_valid_o=1 on the next cycle.
- Throughput: 1 packet/cycle while out_ready_i=1.
- Backpressure: after out_ready_i falls, at most one more push is absorbed (into skid). in_ready_o falls the cycle after skid fills.
- in_ready_o depends only on registered state. Upstream must hold payload stable while in_valid_i=1 and in_ready_o=0.
- out_* payload and out_valid_o are stable while out_valid_o=1 and out_ready_i=0, except when changed by a flush.
- Reset asserted mid-transfer discards both entries without completing any handshake.

## Test plan
- Reset then single push (warp 3, mask 0xFFFF_FFFF), out_ready_i=1 → out_valid_o=1 one cycle later with identical payload; count_o returns 0 the cycle after pop.
- Stream 8 packets, out_ready_i=1 throughout → 8 consecutive out_valid_o cycles in order, in_ready_o never 0.
- out_ready_i=0 during a stream → count_o reaches 2, in_ready_o=0; exactly one extra packet is absorbed. On release, output order is main then skid with no loss or duplicate.
- GATE_INACTIVE=1, mask 0x0000_0005, all lanes 0xAA.. → only lanes 0 and 2 are nonzero at output; out_mask_o=0x0000_0005.
- FULL with main warp 2 and skid warp 5; flush_i=1, flush_warp_i=2, out_ready_i=0 → next cycle main holds the warp-5 packet, count_o=1, drop_cnt_o=1.
- flush_all_i with flush_i during a push into FULL-after-pop → all entries and the input are dropped, count_o=0. drop_cnt_o saturates at 255 after repeated flushes.
